// File: rtl/bip_debug_ctrl.sv
// UART-side debug/execution controller for the BIP cpu.
// Loads program memory from received bytes, runs or single-steps the cpu
// through its reset and clock enable, and dumps PC/ACC/cycle count as six bytes.
module bip_debug_ctrl #(
    parameter int NBITS_O = 11,
    parameter int NBITS_D = 16,
    parameter int OPCODE  = 5,
    parameter int NBITS_B = 8,
    parameter int NBITS_C = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NBITS_B-1:0] i_RxData,
    input  logic               i_RxDone,
    input  logic               i_TxDone,
    output logic [NBITS_B-1:0] o_TxData,
    output logic               o_TxStart,
    input  logic [NBITS_O-1:0] i_PmAddr,
    input  logic [NBITS_D-1:0] i_Instruction,
    input  logic [NBITS_D-1:0] i_Acc,
    output logic               o_CpuEnable,
    output logic               o_CpuReset,
    output logic               o_PmWrEn,
    output logic [NBITS_O-1:0] o_PmWrAddr,
    output logic [NBITS_D-1:0] o_PmWrData,
    output logic               o_Halted
);

    localparam int DUMP_W = 48;
    localparam int LAST_BYTE = 5;

    localparam logic [NBITS_B-1:0] CMD_LOAD = 8'h4C;
    localparam logic [NBITS_B-1:0] CMD_RUN  = 8'h52;
    localparam logic [NBITS_B-1:0] CMD_STEP = 8'h53;
    localparam logic [NBITS_B-1:0] CMD_DUMP = 8'h44;

    typedef enum logic [3:0] {
        IDLE,
        LD_CNT_H,
        LD_CNT_L,
        LD_DATA_H,
        LD_DATA_L,
        LD_WRITE,
        RUN,
        STEP,
        DUMP_SEND,
        DUMP_WAIT
    } state_t;

    state_t               r_state;
    logic                 r_cpuReset;
    logic                 r_halted;
    logic                 r_pmWrEn;
    logic [NBITS_O-1:0]   r_pmWrAddr;
    logic [NBITS_D-1:0]   r_pmWrData;
    logic                 r_txStart;
    logic [NBITS_B-1:0]   r_txData;
    logic [NBITS_B-1:0]   r_hiByte;
    logic [NBITS_O-1:0]   r_wordCount;
    logic [NBITS_O-1:0]   r_wordIdx;
    logic [NBITS_C-1:0]   r_cycle;
    logic [DUMP_W-1:0]    r_dump;
    logic [2:0]           r_byteIdx;

    logic [OPCODE-1:0]    w_opcode;
    logic                 w_isHalt;
    logic                 w_cpuEnable;
    logic                 w_loadCmd;
    logic [NBITS_O-1:0]   w_loadCount;
    logic [NBITS_D-1:0]   w_word;
    logic [DUMP_W-1:0]    w_snapshot;
    logic                 w_unusedOperand;

    // Opcode 0 is HALT; the cpu is only clocked while loaded and not halted.
    assign w_opcode    = i_Instruction[NBITS_D-1 -: OPCODE];
    assign w_isHalt    = (w_opcode == '0);
    assign w_cpuEnable = r_cpuReset && !w_isHalt && ((r_state == RUN) || (r_state == STEP));
    assign w_loadCmd   = (r_state == IDLE) && i_RxDone && (i_RxData == CMD_LOAD);
    assign w_loadCount = NBITS_O'({r_hiByte, i_RxData});
    assign w_word      = NBITS_D'({r_hiByte, i_RxData});
    assign w_snapshot  = {16'(i_PmAddr), 16'(i_Acc), 16'(r_cycle)};
    assign w_unusedOperand = ^i_Instruction[NBITS_D-OPCODE-1:0];

    // Count every cycle the cpu is clocked, saturating; a new load starts from zero.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cycle <= '0;
        end else if (w_loadCmd) begin
            r_cycle <= '0;
        end else if (w_cpuEnable && (r_cycle != '1)) begin
            r_cycle <= r_cycle + NBITS_C'(1);
        end
    end

    // Command decoder, program loader, run/step sequencer and dump transmitter.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_cpuReset  <= 1'b0;
            r_halted    <= 1'b0;
            r_pmWrEn    <= 1'b0;
            r_pmWrAddr  <= '0;
            r_pmWrData  <= '0;
            r_txStart   <= 1'b0;
            r_txData    <= '0;
            r_hiByte    <= '0;
            r_wordCount <= '0;
            r_wordIdx   <= '0;
            r_dump      <= '0;
            r_byteIdx   <= '0;
        end else begin
            r_pmWrEn  <= 1'b0;
            r_txStart <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_RxDone) begin
                        case (i_RxData)
                            CMD_LOAD: begin
                                r_cpuReset <= 1'b0;
                                r_halted   <= 1'b0;
                                r_wordIdx  <= '0;
                                r_state    <= LD_CNT_H;
                            end
                            CMD_RUN:  r_state <= RUN;
                            CMD_STEP: r_state <= STEP;
                            CMD_DUMP: begin
                                r_dump    <= w_snapshot;
                                r_byteIdx <= '0;
                                r_state   <= DUMP_SEND;
                            end
                            default: r_state <= IDLE;
                        endcase
                    end
                end
                LD_CNT_H: begin
                    if (i_RxDone) begin
                        r_hiByte <= i_RxData;
                        r_state  <= LD_CNT_L;
                    end
                end
                LD_CNT_L: begin
                    if (i_RxDone) begin
                        if (w_loadCount == '0) begin
                            r_cpuReset <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_wordCount <= w_loadCount;
                            r_state     <= LD_DATA_H;
                        end
                    end
                end
                LD_DATA_H: begin
                    if (i_RxDone) begin
                        r_hiByte <= i_RxData;
                        r_state  <= LD_DATA_L;
                    end
                end
                LD_DATA_L: begin
                    if (i_RxDone) begin
                        r_pmWrEn   <= 1'b1;
                        r_pmWrAddr <= r_wordIdx;
                        r_pmWrData <= w_word;
                        r_state    <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    r_wordIdx <= r_wordIdx + NBITS_O'(1);
                    if (r_wordIdx == (r_wordCount - NBITS_O'(1))) begin
                        r_cpuReset <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_state <= LD_DATA_H;
                    end
                end
                RUN: begin
                    if (!r_cpuReset) begin
                        r_state <= IDLE;
                    end else if (w_isHalt) begin
                        r_halted <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                STEP: begin
                    if (r_cpuReset && w_isHalt) begin
                        r_halted <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                DUMP_SEND: begin
                    r_txStart <= 1'b1;
                    r_txData  <= r_dump[DUMP_W-1 -: NBITS_B];
                    r_state   <= DUMP_WAIT;
                end
                DUMP_WAIT: begin
                    if (i_TxDone) begin
                        if (r_byteIdx == 3'(LAST_BYTE)) begin
                            r_state <= IDLE;
                        end else begin
                            r_byteIdx <= r_byteIdx + 3'd1;
                            r_dump    <= {r_dump[DUMP_W-NBITS_B-1:0], NBITS_B'(0)};
                            r_state   <= DUMP_SEND;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_CpuEnable = w_cpuEnable;
    assign o_CpuReset  = r_cpuReset;
    assign o_PmWrEn    = r_pmWrEn;
    assign o_PmWrAddr  = r_pmWrAddr;
    assign o_PmWrData  = r_pmWrData;
    assign o_TxStart   = r_txStart;
    assign o_TxData    = r_txData;
    assign o_Halted    = r_halted;

endmodule

// File: doc/bip_debug_ctrl.md
Name: bip_debug_ctrl

Overview:
- UART-side debug/execution controller for the BIP cpu.
- Receives command bytes from a UART receiver and loads program memory word by word.
- Sequences the cpu through its reset and clock-enable: free run until HALT, or single step.
- Returns PC, accumulator and an executed-cycle count as a 6-byte dump through a UART transmitter.

Parameters:
NBITS_O, 11, program-memory address / PC width
NBITS_D, 16, instruction and accumulator width
OPCODE, 5, opcode field width (instruction bits [NBITS_D-1 -: OPCODE])
NBITS_B, 8, UART byte width
NBITS_C, 16, executed-cycle counter width

Ports:
i_clock  in  1  system clock, all state on rising edge
i_reset  in  1  asynchronous, active-low reset
i_RxData  in  NBITS_B  received byte, valid when i_RxDone=1
i_RxDone  in  1  one-cycle strobe, new byte on i_RxData
i_TxDone  in  1  one-cycle strobe, transmitter finished current byte
o_TxData  out  NBITS_B  byte to transmit, stable from o_TxStart until i_TxDone
o_TxStart  out  1  one-cycle transmit request
i_PmAddr  in  NBITS_O  cpu PC (cpu o_PmAddr)
i_Instruction  in  NBITS_D  program-memory word at i_PmAddr
i_Acc  in  NBITS_D  cpu accumulator
o_CpuEnable  out  1  cpu clock enable
o_CpuReset  out  1  active-low reset to cpu
o_PmWrEn  out  1  program-memory write strobe
o_PmWrAddr  out  NBITS_O  program-memory write address
o_PmWrData  out  NBITS_D  program-memory write data
o_Halted  out  1  cpu stopped on HALT (opcode 0)

Behaviour:
- Reset values:
  - FSM in IDLE.
  - o_CpuReset=0, o_CpuEnable=0, o_TxStart=0, o_PmWrEn=0, o_Halted=0.
  - o_PmWrAddr=0, o_PmWrData=0, o_TxData=0.
  - Cycle counter and word count cleared.
- Reset is asynchronous; asserting it mid-load, mid-run or mid-dump aborts immediately to the reset values.
- States: IDLE, LD_CNT_H, LD_CNT_L, LD_DATA_H, LD_DATA_L, LD_WRITE, RUN, STEP, DUMP_SEND, DUMP_WAIT.
- Commands are accepted only in IDLE on i_RxDone. Any other byte is ignored and the FSM stays in IDLE.
  - 0x4C 'L' -> LD_CNT_H. Sets o_CpuReset=0, clears o_Halted and the cycle counter.
  - 0x52 'R' -> RUN.
  - 0x53 'S' -> STEP.
  - 0x44 'D' -> DUMP_SEND. Snapshots {PC, ACC, CYC} into a 48-bit shift register, byte index=0.
- Load sequence:
  - LD_CNT_H / LD_CNT_L each take one byte, forming N = {hi,lo}[NBITS_O-1:0]. Upper bits are discarded.
  - If N=0 after LD_CNT_L: go to IDLE, o_CpuReset=1, no write.
  - LD_DATA_H / LD_DATA_L take the instruction word MSB first.
  - LD_WRITE lasts exactly 1 cycle. It drives o_PmWrEn=1 with o_PmWrAddr=word index and o_PmWrData={hi,lo}, then increments the index.
  - After word N-1: go to IDLE and set o_CpuReset=1. Otherwise return to LD_DATA_H.
  - Word index starts at 0.
- HALT = i_Instruction opcode field == 0.
- RUN:
  - o_CpuEnable = 1 combinationally while in RUN and opcode != 0.
  - In the first cycle opcode == 0: o_CpuEnable=0, set o_Halted, go to IDLE.
  - i_RxDone is ignored during RUN.
- STEP:
  - If opcode != 0: o_CpuEnable=1 for exactly one cycle.
  - If opcode == 0: o_CpuEnable stays 0 and o_Halted is set.
  - Returns to IDLE after 1 cycle.
- R or S while o_CpuReset=0 (nothing loaded yet): o_CpuEnable stays 0, return to IDLE in 1 cycle.
- Cycle counter:
  - Increments on every cycle with o_CpuEnable=1.
  - Saturates at all-ones.
  - Cleared only by reset or by 'L'.
- Dump:
  - DUMP_SEND pulses o_TxStart for 1 cycle with o_TxData = current byte, then moves to DUMP_WAIT.
  - On i_TxDone: increment byte index; after byte 5 go to IDLE, otherwise return to DUMP_SEND.
  - Byte order: PC hi, PC lo, ACC hi, ACC lo, CYC hi, CYC lo. PC is zero-extended to 16 bits.
  - i_RxDone is ignored during the dump.
- i_RxDone and i_TxDone arriving in the same cycle: only the input relevant to the current state is acted on.

Test Plan:
- Reset low mid-LD_DATA_L -> all outputs at reset values. A following 'D' returns PC from cpu, CYC=0x0000.
- 'L',0x00,0x03 then words 0x0805,0x1003,0x0000 -> three o_PmWrEn pulses at addr 0,1,2 with exact data; o_CpuReset rises after the third write.
- After that load, 'R' -> o_CpuEnable high for exactly 2 cycles, o_Halted=1. 'D' sends 00 02 aa aa 00 02, with ACC bytes matching i_Acc.
- Reload a non-HALT program, 'S' three times -> exactly three single-cycle enables; dump shows CYC=0x0003.
- 'L',0x00,0x00 -> no write, o_CpuReset=1, back in IDLE. Unknown byte 0x7A in IDLE -> no output change.
- 'R' before any load -> o_CpuEnable never asserts. Dump with i_TxDone delayed 50 cycles -> o_TxStart waits, exactly 6 pulses total.
